// File: rtl/bp_stage_pkg.sv
// Shared constants and types for the branch prediction stage.
// Holds the FE/BP/AGEX bundle widths, default table sizes and the
// PHT reset value.
package bp_stage_pkg;

  localparam int DBITS_DEF        = 32;
  localparam int BTB_IDX_BITS_DEF = 4;
  localparam int PHT_IDX_BITS_DEF = 8;

  localparam int FROM_FE_TO_BP_WIDTH   = DBITS_DEF;
  localparam int FROM_BP_TO_FE_WIDTH   = DBITS_DEF + 1;
  localparam int FROM_AGEX_TO_BP_WIDTH = 3 * DBITS_DEF + 2;

  typedef enum logic [1:0] {
    PHT_SNT = 2'b00,
    PHT_WNT = 2'b01,
    PHT_WT  = 2'b10,
    PHT_ST  = 2'b11
  } pht_cnt_e;

  // Counters come out of reset weakly not-taken.
  localparam logic [1:0] PHT_RESET_VAL = PHT_WNT;

endpackage

// File: rtl/bp_stage_sat_counter2.sv
// sat_counter2: combinational 2-bit saturating up/down step used on the
// PHT training path. Holds at strongly-taken / strongly-not-taken.
module sat_counter2
  import bp_stage_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next
);

  // Step toward the resolved direction, clamping at both ends.
  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != PHT_ST) cnt_next = cnt + 2'b01;
    end else begin
      if (cnt != PHT_SNT) cnt_next = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/bp_stage.sv
// bp_stage: branch predictor serving FE. Zero-latency lookup of a
// direct-mapped BTB plus a 2-bit PHT; trained by AGEX resolutions and
// redirects FE on a mispredict.
// Build option: BP_GSHARE_EN -- index the PHT with PC XOR global history.
// Without it the PHT is bimodal and no history register exists.
module bp_stage
  import bp_stage_pkg::*;
#(
  parameter int DBITS        = DBITS_DEF,
  parameter int BTB_IDX_BITS = BTB_IDX_BITS_DEF,
  parameter int PHT_IDX_BITS = PHT_IDX_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DBITS-1:0]   from_FE_to_BP,
  input  logic [3*DBITS+1:0] from_AGEX_to_BP,
  output logic [DBITS:0]     from_BP_to_FE
);

  localparam int BTB_N    = 1 << BTB_IDX_BITS;
  localparam int PHT_N    = 1 << PHT_IDX_BITS;
  localparam int TAG_BITS = DBITS - BTB_IDX_BITS - 2;

  logic [DBITS-1:0] pc;
  logic             br_valid;
  logic             br_taken;
  logic [DBITS-1:0] br_target;
  logic [DBITS-1:0] br_pc;
  logic [DBITS-1:0] br_pred_npc;

  assign pc = from_FE_to_BP;
  assign {br_valid, br_taken, br_target, br_pc, br_pred_npc} = from_AGEX_to_BP;

  logic [BTB_N-1:0]    btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [BTB_N];
  logic [DBITS-1:0]    btb_target [BTB_N];
  logic [1:0]          pht        [PHT_N];
  logic [DBITS-1:0]    mispred_count;

  logic [BTB_IDX_BITS-1:0] lk_btb_idx;
  logic [TAG_BITS-1:0]     lk_tag;
  logic [PHT_IDX_BITS-1:0] lk_pht_idx;
  logic [BTB_IDX_BITS-1:0] tr_btb_idx;
  logic [TAG_BITS-1:0]     tr_tag;
  logic [PHT_IDX_BITS-1:0] tr_pht_idx;
  logic [1:0]              pht_next;

  logic             pred_taken;
  logic [DBITS-1:0] pc_plus4;
  logic [DBITS-1:0] actual_npc;
  logic             mispredict;
  logic             flush;
  logic [DBITS-1:0] bp_pc;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{pc[1:0], br_pc[1:0]};

  assign lk_btb_idx = pc[BTB_IDX_BITS+1:2];
  assign lk_tag     = pc[DBITS-1:BTB_IDX_BITS+2];
  assign tr_btb_idx = br_pc[BTB_IDX_BITS+1:2];
  assign tr_tag     = br_pc[DBITS-1:BTB_IDX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [PHT_IDX_BITS-1:0] ghr;

  // History advances only when a branch resolves, never at fetch.
  always_ff @(posedge clk) begin
    if (reset) ghr <= '0;
    else if (br_valid) ghr <= {ghr[PHT_IDX_BITS-2:0], br_taken};
  end

  assign lk_pht_idx = pc[PHT_IDX_BITS+1:2] ^ ghr;
  assign tr_pht_idx = br_pc[PHT_IDX_BITS+1:2] ^ ghr;
`else
  assign lk_pht_idx = pc[PHT_IDX_BITS+1:2];
  assign tr_pht_idx = br_pc[PHT_IDX_BITS+1:2];
`endif

  assign pred_taken = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag)
                      && pht[lk_pht_idx][1];
  assign pc_plus4   = pc + DBITS'(4);
  assign actual_npc = br_taken ? br_target : br_pc + DBITS'(4);
  assign mispredict = br_valid && (actual_npc != br_pred_npc);

  sat_counter2 u_pht_step (
    .cnt      (pht[tr_pht_idx]),
    .inc      (br_taken),
    .cnt_next (pht_next)
  );

  // Redirect beats lookup; reset masks both so FE sees plain sequential fetch.
  always_comb begin
    flush = 1'b0;
    bp_pc = pc_plus4;
    if (!reset) begin
      if (mispredict) begin
        flush = 1'b1;
        bp_pc = actual_npc;
      end else if (pred_taken) begin
        bp_pc = btb_target[lk_btb_idx];
      end
    end
  end

  assign from_BP_to_FE = {flush, bp_pc};

  // PHT: reset to weakly not-taken, then train one counter per resolution.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) pht[PHT_IDX_BITS'(i)] <= PHT_RESET_VAL;
    end else if (br_valid) begin
      pht[tr_pht_idx] <= pht_next;
    end
  end

  // BTB valid bits: only taken branches allocate; nothing invalidates.
  always_ff @(posedge clk) begin
    if (reset) btb_valid <= '0;
    else if (br_valid && br_taken) btb_valid[tr_btb_idx] <= 1'b1;
  end

  // BTB payload needs no reset; it is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (br_valid && br_taken && !reset) begin
      btb_tag[tr_btb_idx]    <= tr_tag;
      btb_target[tr_btb_idx] <= br_target;
    end
  end

  // Debug-only mispredict tally; wraps freely.
  always_ff @(posedge clk) begin
    if (reset) mispred_count <= '0;
    else if (mispredict) mispred_count <= mispred_count + DBITS'(1);
  end

endmodule

// File: tb/tb_bp_stage.sv
// Directed bench for bp_stage. Expected values are worked out by hand for
// the default (bimodal) build; the history-dependent vectors carry the
// BP_GSHARE_EN variants alongside.
module tb_bp_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fe;
  logic [97:0] agex;
  logic [32:0] to_fe;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_stage dut (
    .clk             (clk),
    .reset           (reset),
    .from_FE_to_BP   (fe),
    .from_AGEX_to_BP (agex),
    .from_BP_to_FE   (to_fe)
  );

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got flush=%0b bp_pc=%h, expected flush=%0b bp_pc=%h",
               tag, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then move past the edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic v, input logic t,
                      input logic [31:0] tgt, input logic [31:0] brpc, input logic [31:0] pred,
                      input logic ef, input logic [31:0] epc);
    fe   = pc;
    agex = {v, t, tgt, brpc, pred};
    @(negedge clk);
    check_eq(tag, to_fe, {ef, epc});
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] epc);
    step(tag, pc, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, epc);
  endtask

  // Resolution of the branch at pc while FE is fetching that same pc.
  task automatic res(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic [31:0] pred, input logic ef, input logic [31:0] epc);
    step(tag, pc, 1'b1, t, tgt, pc, pred, ef, epc);
  endtask

  initial begin
    logic        tk;
    logic [31:0] pred;
    logic        ef;
    logic [31:0] epc;

    // Reset holds off redirects even with a mispredicting resolution present.
    reset = 1'b1;
    step("rst_hold0", 32'h100, 1'b1, 1'b1, 32'h900, 32'h100, 32'h104, 1'b0, 32'h104);
    step("rst_hold1", 32'h100, 1'b1, 1'b1, 32'h900, 32'h100, 32'h104, 1'b0, 32'h104);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) look($sformatf("idle%0d", i), 32'h100, 32'h104);

`ifndef BP_GSHARE_EN
    // Counter walk at 0x100: 01 ->10 ->01 ->00 ->00 ->01 ->10 ->11 ->11 ->10.
    res ("train_t",      32'h100, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
    look("hit_after_t",  32'h100, 32'h200);
    res ("nt1_redirect", 32'h100, 1'b0, 32'h200, 32'h200, 1'b1, 32'h104);
    look("after_nt1",    32'h100, 32'h104);
    res ("nt2_correct",  32'h100, 1'b0, 32'h200, 32'h104, 1'b0, 32'h104);
    look("after_nt2",    32'h100, 32'h104);
    res ("nt3_floor",    32'h100, 1'b0, 32'h200, 32'h104, 1'b0, 32'h104);
    res ("t_from_00",    32'h100, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
    look("no_underflow", 32'h100, 32'h104);
    res ("t_to_10",      32'h100, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
    look("hit_10",       32'h100, 32'h200);
    res ("t_correct",    32'h100, 1'b1, 32'h200, 32'h200, 1'b0, 32'h200);
    res ("t_ceiling",    32'h100, 1'b1, 32'h200, 32'h200, 1'b0, 32'h200);
    res ("nt_from_11",   32'h100, 1'b0, 32'h200, 32'h200, 1'b1, 32'h104);
    look("no_overflow",  32'h100, 32'h200);
`endif

    // Aliasing: 0x100 and 0x140 share BTB slot 0 with different tags.
    reset = 1'b1;
    look("rst_alias", 32'h100, 32'h104);
    reset = 1'b0;
    res ("alias_t100", 32'h100, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
    res ("alias_t140", 32'h140, 1'b1, 32'h300, 32'h144, 1'b1, 32'h300);
    look("alias_miss", 32'h100, 32'h104);
`ifdef BP_GSHARE_EN
    look("alias_140",  32'h140, 32'h144);
`else
    look("alias_140",  32'h140, 32'h300);
`endif

    // Reset in mid-operation throws away the trained entry.
    reset = 1'b1;
    step("rst_mid", 32'h140, 1'b1, 1'b1, 32'h900, 32'h140, 32'h144, 1'b0, 32'h144);
    reset = 1'b0;
    look("post_rst", 32'h140, 32'h144);

    look("pc_wrap", 32'hFFFF_FFFC, 32'h0000_0000);

    // Alternating T/NT at 0x180 (target 0x280) from a clean history.
    for (int r = 1; r <= 16; r++) begin
      tk = r[0];
`ifdef BP_GSHARE_EN
      if (tk) begin
        pred = (r <= 9) ? 32'h184 : 32'h280;
        ef   = (r <= 9);
        epc  = 32'h280;
      end else begin
        pred = 32'h184;
        ef   = 1'b0;
        epc  = 32'h184;
      end
`else
      pred = tk ? 32'h184 : 32'h280;
      ef   = 1'b1;
      epc  = tk ? 32'h280 : 32'h184;
`endif
      res($sformatf("alt%0d", r), 32'h180, tk, 32'h280, pred, ef, epc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
